// File: rtl/mandelbrot_mem_pkg.sv
// Shared DDR2/MCB constants, default frame geometry and state encoding for the
// Mandelbrot iteration frame writer and reader.
package mandelbrot_mem_pkg;

    localparam logic [2:0]  MCB_INSTR_WRITE  = 3'b000;
    localparam logic [2:0]  MCB_INSTR_READ   = 3'b001;

    localparam logic [29:0] FRAME0_BASE_ADDR = 30'h0000000;
    localparam logic [29:0] FRAME1_BASE_ADDR = 30'h0400000;

    localparam int RES_H_PIXELS  = 1280;
    localparam int RES_V_LINES   = 720;
    localparam int RD_BURST_LEN  = 32;
    localparam int RD_FLUSH_IDLE = 32;

    typedef enum logic [2:0] {
        ST_FLUSH = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } frame_state_t;

    // Counter width that never collapses to zero bits for degenerate sizes.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster position tracker: word index plus x/y with wrap, and decoded
// start-of-line / end-of-line / last-of-frame flags for the current word.
module raster_counter
    import mandelbrot_mem_pkg::*;
#(
    parameter int H_PIXELS = RES_H_PIXELS,
    parameter int V_LINES  = RES_V_LINES,
    parameter int X_W      = clog2_min1(H_PIXELS),
    parameter int Y_W      = clog2_min1(V_LINES),
    parameter int IDX_W    = clog2_min1(H_PIXELS * V_LINES)
) (
    input  logic             clk,
    input  logic             i_srst_n,
    input  logic             i_clear,
    input  logic             i_advance,
    output logic [IDX_W-1:0] o_word_index,
    output logic             o_sol,
    output logic             o_eol,
    output logic             o_last
);

    localparam logic [X_W-1:0] X_MAX = X_W'(H_PIXELS - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_LINES - 1);

    logic [IDX_W-1:0] r_word_index;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;

    always_ff @(posedge clk) begin
        if (!i_srst_n || i_clear) begin
            r_word_index <= '0;
            r_x          <= '0;
            r_y          <= '0;
        end else if (i_advance) begin
            r_word_index <= r_word_index + 1'b1;
            if (r_x == X_MAX) begin
                r_x <= '0;
                r_y <= (r_y == Y_MAX) ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign o_word_index = r_word_index;
    assign o_sol        = (r_x == '0);
    assign o_eol        = (r_x == X_MAX);
    assign o_last       = (r_x == X_MAX) && (r_y == Y_MAX);

endmodule

// File: rtl/iteration_frame_reader.sv
// Streams one stored iteration frame out of DDR2 through a read-only MCB port,
// one burst outstanding at a time, as a valid/ready stream with raster markers.
module iteration_frame_reader
    import mandelbrot_mem_pkg::*;
#(
    parameter int          H_PIXELS    = RES_H_PIXELS,
    parameter int          V_LINES     = RES_V_LINES,
    parameter int          BURST_LEN   = RD_BURST_LEN,
    parameter logic [29:0] FRAME0_BASE = FRAME0_BASE_ADDR,
    parameter logic [29:0] FRAME1_BASE = FRAME1_BASE_ADDR,
    parameter int          FLUSH_IDLE  = RD_FLUSH_IDLE
) (
    input  logic        clk,
    input  logic        SYS_RESETn,
    input  logic        start,
    input  logic        frame_sel,
    input  logic        mem_calib_done,
    input  logic        cmd_full,
    output logic        cmd_en,
    output logic [2:0]  cmd_instr,
    output logic [5:0]  cmd_bl,
    output logic [29:0] cmd_byte_addr,
    input  logic [31:0] rd_data,
    input  logic        rd_empty,
    input  logic [6:0]  rd_count,
    output logic        rd_en,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sol,
    output logic        out_eol,
    output logic        out_last,
    output logic        busy,
    output logic        frame_done
);

    localparam int IDX_W = clog2_min1(H_PIXELS * V_LINES);
    localparam int BC_W  = clog2_min1(BURST_LEN);
    localparam int FC_W  = $clog2(FLUSH_IDLE + 1);
    localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST_LEN - 1);
    localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_IDLE - 1);

    frame_state_t     r_state, w_state_next;
    logic [29:0]      r_base, r_cmd_addr;
    logic [BC_W-1:0]  r_burst_cnt;
    logic [FC_W-1:0]  r_idle_cnt;
    logic [IDX_W-1:0] w_word_index;
    logic [29:0]      w_base_sel, w_next_off;
    logic             w_go, w_xfer, w_burst_last, w_flush_done;
    logic             w_sol, w_eol, w_last;
    logic             w_unused_rd_count;

    assign w_go         = start & mem_calib_done;
    assign w_xfer       = (r_state == ST_DRAIN) & ~rd_empty & out_ready;
    assign w_burst_last = (r_burst_cnt == BURST_LAST);
    assign w_flush_done = rd_empty && (r_idle_cnt == FLUSH_LAST);
    assign w_base_sel   = frame_sel ? FRAME1_BASE : FRAME0_BASE;
    // Byte offset of the word after the one being accepted: the next burst's start.
    assign w_next_off   = (30'(w_word_index) + 30'd1) << 2;
    assign w_unused_rd_count = ^rd_count;

    raster_counter #(
        .H_PIXELS (H_PIXELS),
        .V_LINES  (V_LINES),
        .IDX_W    (IDX_W)
    ) u_raster (
        .clk          (clk),
        .i_srst_n     (SYS_RESETn),
        .i_clear      ((r_state == ST_IDLE) && w_go),
        .i_advance    (w_xfer),
        .o_word_index (w_word_index),
        .o_sol        (w_sol),
        .o_eol        (w_eol),
        .o_last       (w_last)
    );

    always_ff @(posedge clk) begin
        if (!SYS_RESETn) r_state <= ST_FLUSH;
        else             r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FLUSH: if (w_flush_done) w_state_next = ST_IDLE;
            ST_IDLE:  if (w_go)         w_state_next = ST_ISSUE;
            ST_ISSUE: if (!cmd_full)    w_state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (w_xfer && w_last)            w_state_next = ST_DONE;
                else if (w_xfer && w_burst_last) w_state_next = ST_ISSUE;
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_FLUSH;
        endcase
    end

    always_comb begin
        cmd_en     = 1'b0;
        rd_en      = 1'b0;
        out_valid  = 1'b0;
        frame_done = 1'b0;
        busy       = 1'b1;
        case (r_state)
            ST_FLUSH: rd_en = ~rd_empty;
            ST_IDLE:  busy = 1'b0;
            ST_ISSUE: cmd_en = ~cmd_full;
            ST_DRAIN: begin
                out_valid = ~rd_empty;
                rd_en     = w_xfer;
            end
            ST_DONE:  frame_done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!SYS_RESETn) begin
            r_base      <= '0;
            r_cmd_addr  <= '0;
            r_burst_cnt <= '0;
            r_idle_cnt  <= '0;
        end else begin
            if (r_state == ST_FLUSH) r_idle_cnt <= rd_empty ? r_idle_cnt + 1'b1 : '0;
            else                     r_idle_cnt <= '0;

            // Address is settled before ISSUE is entered so it never moves while a command waits.
            if ((r_state == ST_IDLE) && w_go) begin
                r_base     <= w_base_sel;
                r_cmd_addr <= w_base_sel;
            end else if (w_xfer && w_burst_last && !w_last) begin
                r_cmd_addr <= r_base + w_next_off;
            end

            if ((r_state == ST_ISSUE) && !cmd_full) r_burst_cnt <= '0;
            else if (w_xfer)                        r_burst_cnt <= r_burst_cnt + 1'b1;
        end
    end

    assign cmd_instr     = MCB_INSTR_READ;
    assign cmd_bl        = 6'(BURST_LEN - 1);
    assign cmd_byte_addr = r_cmd_addr;
    assign out_data      = rd_data;
    assign out_sol       = out_valid & w_sol;
    assign out_eol       = out_valid & w_eol;
    assign out_last      = out_valid & w_last;

endmodule

// File: tb/tb_iteration_frame_reader.sv
// Directed-plus-random bench: a queue-based MCB/FIFO model feeds the reader and a
// frame-level reference (address -> word, index -> markers) checks every output.
module tb_iteration_frame_reader;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int B  = 8;
    localparam int FI = 32;
    localparam int N  = H * V;
    localparam logic [29:0] F0 = 30'h0000000;
    localparam logic [29:0] F1 = 30'h0400000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        SYS_RESETn, start, frame_sel, mem_calib_done, cmd_full;
    logic        cmd_en, rd_en, rd_empty, out_valid, out_ready;
    logic        out_sol, out_eol, out_last, busy, frame_done;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic [31:0] rd_data, out_data;
    logic [6:0]  rd_count;

    iteration_frame_reader #(
        .H_PIXELS(H), .V_LINES(V), .BURST_LEN(B),
        .FRAME0_BASE(F0), .FRAME1_BASE(F1), .FLUSH_IDLE(FI)
    ) dut (
        .clk(clk), .SYS_RESETn(SYS_RESETn), .start(start), .frame_sel(frame_sel),
        .mem_calib_done(mem_calib_done), .cmd_full(cmd_full), .cmd_en(cmd_en),
        .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
        .rd_data(rd_data), .rd_empty(rd_empty), .rd_count(rd_count), .rd_en(rd_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sol(out_sol), .out_eol(out_eol), .out_last(out_last),
        .busy(busy), .frame_done(frame_done)
    );

    int vectors = 0, miscompares = 0;
    int cyc = 0, last_nonempty = 0, n_pop = 0;
    int exp_idx, cmds, xfers_since_cmd, done_cnt, last_xfer_cyc;
    int viol_ready, viol_flush, viol_full, viol_under, viol_cap, viol_spur;
    bit in_frame = 0, in_flush = 0;
    logic [29:0] f_base;
    logic [31:0] salt;
    logic [31:0] fifo_q[$];
    logic [29:0] pend_a[$];

    logic        s_busy, s_cmd_en, s_valid, s_sol, s_eol, s_last, s_done;
    logic [2:0]  s_instr;
    logic [5:0]  s_bl;
    logic [29:0] s_addr;

    // Stored frame content: every byte address holds a salted hash of itself.
    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return salt ^ (32'(a) * 32'h9E3779B1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_viol();
        viol_ready = 0; viol_flush = 0; viol_full = 0;
        viol_under = 0; viol_cap = 0; viol_spur = 0;
    endtask

    // One clock cycle: present FIFO head, sample outputs before the edge, update models.
    task automatic tick();
        logic [2:0] m_exp;
        rd_empty = (fifo_q.size() == 0);
        rd_data  = rd_empty ? 32'h0 : fifo_q[0];
        rd_count = 7'(fifo_q.size());
        #1;
        cyc++;
        s_busy = busy; s_cmd_en = cmd_en; s_valid = out_valid; s_sol = out_sol;
        s_eol = out_eol; s_last = out_last; s_done = frame_done;
        s_instr = cmd_instr; s_bl = cmd_bl; s_addr = cmd_byte_addr;
        if (!SYS_RESETn || !rd_empty) last_nonempty = cyc;
        if (out_valid && rd_en && !out_ready) viol_ready++;
        if (in_flush && out_valid) viol_flush++;
        if (cmd_en && cmd_full) viol_full++;
        if (rd_en && rd_empty) viol_under++;
        if (fifo_q.size() > B) viol_cap++;
        if (cmd_en) begin
            if (SYS_RESETn) begin
                if (in_frame) begin
                    $display("cmd %0d addr=%h after %0d words", cmds, cmd_byte_addr, xfers_since_cmd);
                    check("cmd_addr", 64'(cmd_byte_addr), 64'(f_base + 30'(cmds * B * 4)));
                    check("cmd_spacing", 64'(xfers_since_cmd), (cmds == 0) ? 64'd0 : 64'(B));
                    check("cmd_instr_bl", 64'({cmd_instr, cmd_bl}), 64'({3'b001, 6'(B - 1)}));
                end else begin
                    viol_spur++;
                end
            end
            cmds++;
            xfers_since_cmd = 0;
            for (int k = 0; k < B; k++) pend_a.push_back(cmd_byte_addr + 30'(4 * k));
        end
        if (SYS_RESETn && out_valid && rd_en) begin
            if (in_frame && exp_idx < N) begin
                m_exp = {(exp_idx % H) == 0, (exp_idx % H) == H - 1, exp_idx == N - 1};
                check("word_data", 64'(out_data), 64'(mem_word(f_base + 30'(exp_idx * 4))));
                check("word_markers", 64'({out_sol, out_eol, out_last}), 64'(m_exp));
                if (exp_idx == N - 1) last_xfer_cyc = cyc;
                exp_idx++;
                xfers_since_cmd++;
            end else begin
                viol_spur++;
            end
        end
        if (SYS_RESETn && frame_done) begin
            done_cnt++;
            if (in_frame) check("done_latency", 64'(cyc - last_xfer_cyc), 64'd1);
        end
        if (rd_en && !rd_empty) begin
            void'(fifo_q.pop_front());
            n_pop++;
        end
        if (pend_a.size() > 0 && $urandom_range(3) != 0) fifo_q.push_back(mem_word(pend_a.pop_front()));
        @(negedge clk);
    endtask

    task automatic do_reset(input int preload);
        bit ok;
        SYS_RESETn = 1'b0; start = 1'b0; out_ready = 1'b1; cmd_full = 1'b0;
        in_frame = 0; in_flush = 1;
        for (int t = 0; t < 3; t++) tick();
        check("rst_ctrl", 64'({s_cmd_en, s_valid, s_sol, s_eol, s_last, s_done, s_busy}), 64'(7'b0000001));
        check("rst_cmd", 64'({s_instr, s_bl, s_addr}), 64'({3'b001, 6'(B - 1), 30'h0}));
        for (int k = 0; k < preload; k++) fifo_q.push_back($urandom);
        n_pop = 0; viol_flush = 0;
        SYS_RESETn = 1'b1;
        ok = 0;
        for (int t = 0; t < 300; t++) begin
            tick();
            if (!s_busy) begin ok = 1; break; end
        end
        check("flush_reach_idle", 64'(ok), 64'd1);
        check("flush_timing", 64'(cyc), 64'(last_nonempty + 1 + FI));
        check("flush_emptied", 64'(fifo_q.size() + pend_a.size()), 64'd0);
        check("flush_no_valid", 64'(viol_flush), 64'd0);
        if (preload > 0) check("flush_pops", 64'(n_pop), 64'(preload));
        in_flush = 0;
    endtask

    // mode: 0 always ready, 1 ready toggles every cycle, 2 random ready and cmd_full.
    task automatic run_frame(input logic sel, input int mode, input bit hold_full,
                             input bit start_mid, input int abort_at);
        bit held = 0, pulsed = 0;
        int hold_left = 0;
        clear_viol();
        in_frame = 1; f_base = sel ? F1 : F0;
        exp_idx = 0; cmds = 0; xfers_since_cmd = 0; done_cnt = 0; last_xfer_cyc = -10;
        frame_sel = sel; start = 1'b1; out_ready = 1'b1; cmd_full = 1'b0;
        tick();
        for (int t = 0; t < 3000; t++) begin
            if (done_cnt != 0 || (abort_at > 0 && exp_idx >= abort_at)) break;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(1));
            endcase
            cmd_full = (mode == 2) ? ($urandom_range(3) == 0) : 1'b0;
            if (hold_full && !held && exp_idx == B) begin held = 1; hold_left = 10; end
            if (hold_left > 0) cmd_full = 1'b1;
            start = 1'b0;
            if (start_mid && !pulsed && exp_idx == 12) begin
                pulsed = 1; start = 1'b1; frame_sel = ~sel;
            end
            tick();
            if (hold_left > 0) begin
                check("hold_cmd_en", 64'(s_cmd_en), 64'd0);
                check("hold_addr", 64'(s_addr), 64'(f_base + 30'(B * 4)));
                hold_left--;
            end
        end
        start = 1'b0; cmd_full = 1'b0; out_ready = 1'b1;
        if (abort_at > 0) begin
            check("abort_reached", 64'(exp_idx), 64'(abort_at));
            return;
        end
        for (int t = 0; t < 20; t++) tick();
        check("frame_words", 64'(exp_idx), 64'(N));
        check("frame_cmds", 64'(cmds), 64'(N / B));
        check("frame_count", 64'(done_cnt), 64'd1);
        check("idle_after", 64'(s_busy), 64'd0);
        check("ready_gating", 64'(viol_ready), 64'd0);
        check("cmd_while_full", 64'(viol_full), 64'd0);
        check("fifo_underflow", 64'(viol_under + viol_cap), 64'd0);
        check("spurious_activity", 64'(viol_spur), 64'd0);
        in_frame = 0;
    endtask

    initial begin
        salt = $urandom;
        SYS_RESETn = 1'b0; start = 1'b0; frame_sel = 1'b0; mem_calib_done = 1'b1;
        cmd_full = 1'b0; out_ready = 1'b1;
        clear_viol();

        do_reset(5);

        mem_calib_done = 1'b0; frame_sel = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick();
            check("nocal_busy", 64'(s_busy), 64'd0);
        end
        check("nocal_no_cmd", 64'(viol_spur), 64'd0);
        mem_calib_done = 1'b1;

        run_frame(1'b1, 0, 1'b0, 1'b0, 0);
        run_frame(1'b0, 1, 1'b1, 1'b1, 0);
        run_frame(1'b1, 2, 1'b0, 1'b0, 13);
        do_reset(0);
        run_frame(1'b0, 2, 1'b0, 1'b0, 0);
        run_frame(1'b1, 1, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iteration_frame_reader.md
Name: iteration_frame_reader

Overview:
- Read-side counterpart of the port0 iteration writer: streams one stored Mandelbrot iteration frame back out of DDR2 through an MCB user port (read-only), in raster order.
- Issues burst read commands against the selected frame buffer and drains the port read FIFO.
- Presents words on a valid/ready stream with line/frame markers; consumers are colour post-processing and frame-export paths.

Parameters:
- H_PIXELS, 1280, words per line (one 32-bit iteration word per pixel).
- V_LINES, 720, lines per frame.
- BURST_LEN, 32, words per read command (1..64; H_PIXELS*V_LINES must be a multiple).
- FRAME0_BASE, 30'h0000000, byte base of frame 0.
- FRAME1_BASE, 30'h0400000, byte base of frame 1.
- FLUSH_IDLE, 32, consecutive rd_empty cycles that end the post-reset flush.

Ports:
- clk  in  1  port clock, shared with the MCB port clock.
- SYS_RESETn  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to read one frame.
- frame_sel  in  1  frame buffer select (0 = FRAME0_BASE, 1 = FRAME1_BASE); sampled with start.
- mem_calib_done  in  1  MCB calibration complete.
- cmd_full  in  1  MCB command FIFO full.
- cmd_en  out  1  command push strobe.
- cmd_instr  out  3  always 3'b001 (read).
- cmd_bl  out  6  BURST_LEN-1.
- cmd_byte_addr  out  30  base + word_index*4.
- rd_data  in  32  read FIFO head word (first-word-fall-through).
- rd_empty  in  1  read FIFO empty.
- rd_count  in  7  read FIFO occupancy; status only.
- rd_en  out  1  read FIFO pop.
- out_data  out  32  iteration word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accept.
- out_sol  out  1  word is at x == 0.
- out_eol  out  1  word is at x == H_PIXELS-1.
- out_last  out  1  final word of the frame.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- States: FLUSH, IDLE, ISSUE, DRAIN, DONE.
- Reset:
  - State enters FLUSH.
  - All counters cleared.
  - cmd_en=0, frame_done=0, busy=1.
  - out_valid=0, out_sol=0, out_eol=0, out_last=0.
  - cmd_instr=3'b001, cmd_bl=BURST_LEN-1, cmd_byte_addr=0.
- FLUSH:
  - rd_en = ~rd_empty; discards stale FIFO words left by a reset mid-frame. out_valid stays 0.
  - An idle counter increments on rd_empty and clears otherwise.
  - When it reaches FLUSH_IDLE → IDLE.
- IDLE:
  - start & mem_calib_done → ISSUE; latch base from frame_sel; clear word_index, x, y.
  - start while mem_calib_done=0 is dropped.
  - start in any state other than IDLE is ignored.
- ISSUE:
  - cmd_en = ~cmd_full, asserted for exactly one cycle per burst.
  - cmd_byte_addr = base + {word_index, 2'b00}; registered, stable for the whole ISSUE state.
  - On the cycle with cmd_en=1 → DRAIN and clear burst_cnt.
- DRAIN:
  - out_valid = ~rd_empty (combinational from FIFO head); out_data = rd_data.
  - rd_en = out_valid & out_ready; each pop is one transfer.
  - On transfer:
    - Increment burst_cnt and word_index.
    - x wraps at H_PIXELS-1 to 0 and increments y.
  - out_sol/out_eol/out_last are decoded from x, y and are valid only while out_valid.
  - Last word of a burst, not last of frame → ISSUE. Exactly one burst is outstanding at a time.
  - Last word of the frame → DONE.
- DONE:
  - frame_done=1 for one cycle, then → IDLE.
  - busy drops in the same cycle IDLE is entered.
- Backpressure: out_ready=0 holds rd_en=0. The FIFO fills to at most BURST_LEN, so no overflow is possible.
- mem_calib_done falling mid-frame: no special handling; the frame completes when data arrives.
- Arithmetic:
  - word_index width = clog2(H_PIXELS*V_LINES).
  - Address add is 30-bit unsigned; carries beyond bit 29 are discarded.

Decomposition:
- Shared package mandelbrot_mem_pkg holds:
  - MCB instruction constants (READ=3'b001, WRITE=3'b000).
  - Frame base constants, shared with the writer.
  - Resolution constants.
  - State encoding typedef.
- One natural sub-module: raster_counter (x/y/word_index with wrap, sol/eol/last decode), reusable by the writer.

Test Plan:
- Reset with 5 words preloaded in the FIFO → all 5 popped, out_valid never 1; IDLE reached 32 cycles after the FIFO empties.
- H_PIXELS=8, V_LINES=4, BURST_LEN=8, frame_sel=1, start → 4 commands at byte addrs FRAME1_BASE+0, +32, +64, +96.
  - 32 words out in order.
  - out_sol on words 0, 8, 16, 24; out_eol on words 7, 15, 23, 31; out_last on word 31.
  - frame_done 1 cycle after word 31 is accepted.
- out_ready toggled 1-0-1 every cycle → rd_en never asserted while out_ready=0; no word lost or duplicated; a second command is never issued before 8 transfers complete.
- cmd_full held 10 cycles in ISSUE → cmd_en=0 throughout; one cmd_en on release; address unchanged.
- start with mem_calib_done=0 → stays IDLE, busy=0; start during DRAIN → ignored, frame count stays 1.
- Reset asserted mid-frame after word 12 → outputs return to reset values; FLUSH empties the remaining FIFO words; next start reads from word 0.
